// File: rtl/v_wb_buffer.sv
// v_wb_buffer: writeback buffer between the vector ALU result pipeline and the
// VRF write port / scalar result port.
// Show-ahead FIFO. The head entry is routed to exactly one of two valid/ready ports,
// selected by the entry's sca flag. almost_full is registered so ALU issue can be
// throttled early.
// Optional feature: define WB_COALESCE_EN to merge a vector push into the youngest
// queued vector entry that has the same address.
module v_wb_buffer #(
    parameter int unsigned REQ_DATA_WIDTH    = 64,
    parameter int unsigned REQ_ADDR_WIDTH    = 32,
    parameter int unsigned REQ_BE_DATA_WIDTH = REQ_DATA_WIDTH / 8,
    parameter int unsigned DEPTH             = 8,
    parameter int unsigned SKID              = 6
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    input  logic [REQ_ADDR_WIDTH-1:0]    in_addr,
    input  logic [REQ_DATA_WIDTH-1:0]    in_data,
    input  logic [REQ_BE_DATA_WIDTH-1:0] in_be,
    input  logic                         in_w_reg,
    input  logic                         in_sca,
    output logic                         vrf_wr_valid,
    input  logic                         vrf_wr_ready,
    output logic [REQ_ADDR_WIDTH-1:0]    vrf_wr_addr,
    output logic [REQ_DATA_WIDTH-1:0]    vrf_wr_data,
    output logic [REQ_BE_DATA_WIDTH-1:0] vrf_wr_be,
    output logic                         sca_valid,
    input  logic                         sca_ready,
    output logic [REQ_DATA_WIDTH-1:0]    sca_data,
    output logic                         almost_full,
    output logic                         overflow_err
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL_LEVEL = CW'(DEPTH);
    localparam logic [CW-1:0] AF_LEVEL   = CW'(DEPTH - SKID);

    // Entry storage
    logic [REQ_ADDR_WIDTH-1:0]    addr_q [DEPTH];
    logic [REQ_DATA_WIDTH-1:0]    data_q [DEPTH];
    logic [REQ_BE_DATA_WIDTH-1:0] be_q   [DEPTH];
    logic                         sca_q  [DEPTH];

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          almost_full_q, almost_full_d;
    logic          overflow_q, overflow_d;

    logic empty, full, head_sca;
    logic push_req, pop, merge, alloc, drop;

`ifdef WB_COALESCE_EN
    logic [PW-1:0]             young;
    logic [REQ_DATA_WIDTH-1:0] merge_data;
`endif

    // Head routing, handshake decode and next-state pointer/count/flag logic
    always_comb begin
        empty    = (count_q == '0);
        full     = (count_q == FULL_LEVEL);
        head_sca = sca_q[rd_ptr_q];

        vrf_wr_valid = !empty && !head_sca;
        sca_valid    = !empty && head_sca;
        vrf_wr_addr  = empty ? '0 : addr_q[rd_ptr_q];
        vrf_wr_data  = empty ? '0 : data_q[rd_ptr_q];
        vrf_wr_be    = empty ? '0 : be_q[rd_ptr_q];
        sca_data     = empty ? '0 : data_q[rd_ptr_q];

        pop      = (vrf_wr_valid && vrf_wr_ready) || (sca_valid && sca_ready);
        push_req = in_valid && in_w_reg;

`ifdef WB_COALESCE_EN
        young      = wr_ptr_q - 1'b1;
        merge_data = data_q[young];
        for (int unsigned b = 0; b < REQ_BE_DATA_WIDTH; b++) begin
            if (in_be[b]) begin
                merge_data[b*8 +: 8] = in_data[b*8 +: 8];
            end
        end
        // A lone entry leaving this cycle cannot absorb the push; allocate instead
        merge = push_req && !in_sca && !empty && !sca_q[young] &&
                (addr_q[young] == in_addr) &&
                !((count_q == CW'(1)) && pop);
`else
        merge = 1'b0;
`endif

        alloc = push_req && !merge && (!full || pop);
        drop  = push_req && !merge && full && !pop;

        wr_ptr_d = wr_ptr_q + PW'(alloc);
        rd_ptr_d = rd_ptr_q + PW'(pop);
        count_d  = count_q;
        if (alloc && !pop) begin
            count_d = count_q + CW'(1);
        end else if (!alloc && pop) begin
            count_d = count_q - CW'(1);
        end
        almost_full_d = (count_d >= AF_LEVEL);
        overflow_d    = overflow_q || drop;
    end

    // Control state: pointers, occupancy and status flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            almost_full_q <= 1'b0;
            overflow_q    <= 1'b0;
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            almost_full_q <= almost_full_d;
            overflow_q    <= overflow_d;
        end
    end

    // Entry storage writes: allocate at the tail, or merge into the youngest entry
    always_ff @(posedge clk) begin
        if (alloc) begin
            addr_q[wr_ptr_q] <= in_addr;
            data_q[wr_ptr_q] <= in_data;
            be_q[wr_ptr_q]   <= in_be;
            sca_q[wr_ptr_q]  <= in_sca;
        end
`ifdef WB_COALESCE_EN
        else if (merge) begin
            data_q[young] <= merge_data;
            be_q[young]   <= be_q[young] | in_be;
        end
`endif
    end

    assign almost_full  = almost_full_q;
    assign overflow_err = overflow_q;

endmodule
